// File: rtl/internal_bus_slave_pipe_if.sv
// Request/response bus between a bus master and internal_bus_slave_pipe.
// Valid/ready rule for both channels: a beat transfers on a rising clock edge where valid and ready are both 1.
interface internal_bus_slave_pipe_if #(
    parameter int IDBITS   = 4,
    parameter int DATABITS = 512,
    parameter int DEPTH    = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic                mvalid;
    logic                mready;
    logic [IDBITS-1:0]   mid;
    logic [31:0]         maddr;
    logic [DATABITS-1:0] mdata;
    logic                mrw;

    logic                svalid;
    logic                sready;
    logic [IDBITS-1:0]   sid;
    logic [1:0]          sresp;
    logic [DATABITS-1:0] sdata;
    logic                srw;

    logic [CW-1:0]       outstanding;

    modport master (
        output mvalid, mid, maddr, mdata, mrw, sready,
        input  mready, svalid, sid, sresp, sdata, srw, outstanding
    );

    modport slave (
        input  mvalid, mid, maddr, mdata, mrw, sready,
        output mready, svalid, sid, sresp, sdata, srw, outstanding
    );
endinterface

// File: rtl/internal_bus_slave_pipe.sv
// Memory-backed bus slave: requests access storage on acceptance and their responses
// leave an in-order FIFO once a fixed per-entry latency countdown has expired.
module internal_bus_slave_pipe #(
    parameter int    IDBITS   = 4,
    parameter int    DATABITS = 512,
    parameter int    MEMWORDS = 1024,
    parameter int    LATENCY  = 30,
    parameter int    DEPTH    = 4,
    parameter string NAME     = ""
) (
    input  logic                     clock,
    input  logic                     reset_n,
    internal_bus_slave_pipe_if.slave bus
);
    localparam int BYTES = DATABITS / 8;
    localparam int MW    = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    if (LATENCY < 1 || LATENCY > 255 || DEPTH < 1 || DEPTH > 16 || (DATABITS % 8) != 0) begin : g_param_check
        $error("internal_bus_slave_pipe %s: illegal parameter value", NAME);
    end

    // Storage has no reset so its contents survive a bus reset.
    logic [DATABITS-1:0] mem_q [MEMWORDS];

    logic [IDBITS-1:0]   id_q   [DEPTH];
    logic                rw_q   [DEPTH];
    logic [1:0]          resp_q [DEPTH];
    logic [DATABITS-1:0] data_q [DEPTH];
    logic [7:0]          cnt_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]         line_idx;
    logic [MW-1:0]       mem_idx;
    logic                in_range;
    logic                accept;
    logic                pop;
    logic                head_ready;
    logic [1:0]          new_resp;
    logic [DATABITS-1:0] new_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign line_idx = bus.maddr / 32'(BYTES);
    assign mem_idx  = line_idx[MW-1:0];
    assign in_range = (line_idx < 32'(MEMWORDS));

    // mready looks only at the registered count, so a pop cannot free a slot in the same cycle.
    assign bus.mready = (count_q < CW'(DEPTH));
    assign accept     = bus.mvalid & bus.mready;
    assign head_ready = (count_q != '0) && (cnt_q[rd_ptr_q] == 8'd0);
    assign pop        = head_ready & bus.sready;

    assign bus.svalid      = head_ready;
    assign bus.sid         = head_ready ? id_q[rd_ptr_q]   : '0;
    assign bus.sresp       = head_ready ? resp_q[rd_ptr_q] : 2'b00;
    assign bus.sdata       = head_ready ? data_q[rd_ptr_q] : '0;
    assign bus.srw         = head_ready ? rw_q[rd_ptr_q]   : 1'b0;
    assign bus.outstanding = count_q;

    always_comb begin
        new_resp = in_range ? 2'b00 : 2'b10;
        new_data = '0;
        if (bus.mrw && in_range) begin
            new_data = mem_q[mem_idx];
        end
    end

    always_comb begin
        wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !bus.mrw && in_range) begin
            mem_q[mem_idx] <= bus.mdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                rw_q[i]   <= 1'b0;
                resp_q[i] <= 2'b00;
                data_q[i] <= '0;
                cnt_q[i]  <= 8'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Countdowns run for every slot, stalled or not; the new entry overrides its own slot.
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q[i] != 8'd0) begin
                    cnt_q[i] <= cnt_q[i] - 8'd1;
                end
            end
            if (accept) begin
                id_q[wr_ptr_q]   <= bus.mid;
                rw_q[wr_ptr_q]   <= bus.mrw;
                resp_q[wr_ptr_q] <= new_resp;
                data_q[wr_ptr_q] <= new_data;
                cnt_q[wr_ptr_q]  <= 8'(LATENCY - 1);
            end
        end
    end
endmodule
